wishbone_slave_regfile: RTL and testbench
=========================================

# wishbone_slave_regfile

Wishbone classic-cycle responder (slave) fronting a small 64-bit register file: the counterpart of the debug path's Wishbone master, which issues single reads/writes on behalf of JTAG/TAP. Decodes a base-relative address window, applies byte-lane writes, returns read data, and acknowledges exactly once per strobe assertion. This matches a master that keeps `cyc`/`stb` high for a cycle or more after `ack`.

## Interface
Parameters:
- `ADDR_BASE`, 32'h0000_0000: byte address of register 0; must be 8-byte aligned.
- `NUM_REGS`, 16: number of 64-bit registers; range 2..256.
- `WAIT_STATES`, 0: extra cycles inserted before `ack_o`/`err_o`; range 0..15.
- `ID_VALUE`, 64'h5742_534C_0000_0001: read-only contents of register 0.

Ports:
- `clk_i` in 1: clock; all state changes on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-low.
- `cyc_i` in 1: bus cycle valid.
- `stb_i` in 1: strobe; a transfer is requested when `cyc_i & stb_i`.
- `we_i` in 1: 1 = write, 0 = read.
- `adr_i` in 32: byte address; bits [2:0] are ignored.
- `dat_i` in 64: write data.
- `sel_i` in 8: byte-lane enables; bit n covers `dat_i[8n+7:8n]`.
- `dat_o` out 64: read data; registered, held until the next successful read.
- `ack_o` out 1: normal termination; a one-cycle pulse.
- `err_o` out 1: error termination (out-of-window address); a one-cycle pulse.

## Operation
- Index = `(adr_i - ADDR_BASE) >> 3`. In window when `adr_i >= ADDR_BASE` and index < `NUM_REGS`; otherwise out of window.
- FSM states: IDLE, WAIT, RESP, HOLD.
  - IDLE: on `cyc_i & stb_i`, capture `we_i`, index, in-window flag, `dat_i`, `sel_i`. Go to WAIT if `WAIT_STATES > 0`, else RESP. The wait counter loads `WAIT_STATES-1`.
  - WAIT: decrement the counter each cycle; go to RESP when it reaches 0. If `cyc_i` or `stb_i` drops, abort to IDLE with no write and no response.
  - RESP: raise `ack_o` (in window) or `err_o` (out of window) for exactly one cycle, then go to HOLD.
  - HOLD: stay until `stb_i == 0` or `cyc_i == 0`, then go to IDLE. A held strobe never produces a second response.
- Write (in window, index ≠ 0): on the edge entering RESP, update each byte lane whose `sel` bit is 1 using the captured data. Lanes with `sel` = 0 are unchanged.
- Write to index 0: acknowledged, no storage change.
- Read (in window): on the edge entering RESP, load `dat_o` with the register value, or `ID_VALUE` for index 0. `sel` is ignored for reads; `dat_o` is always full width.
- Out of window: `err_o`, no write, `dat_o` unchanged.
- `ack_o` and `err_o` are never high together.

## Timing
- Reset (asynchronous, `rst_i` = 0), any state including mid-transfer:
  - FSM to IDLE; `ack_o` = 0, `err_o` = 0, `dat_o` = 0.
  - Registers 1..N-1 = 0; wait counter = 0.
  - A pending write is dropped.
- Latency: request sampled in IDLE at edge k; response is high during cycle k+1+`WAIT_STATES`.
- Write data is visible to a read issued in the cycle after `ack_o`.
- `dat_o` is valid from the `ack_o` cycle onward and is stable through HOLD and IDLE until the next in-window read response.
- Inputs are sampled only in IDLE; changes to `adr_i`/`dat_i`/`we_i` during WAIT/HOLD have no effect.
- Minimum back-to-back spacing: ack, then at least one cycle with `stb_i` low, then the next request.

## Structure
- Shared package `wb_pkg`:
  - `WB_ADDR_W` = 32, `WB_DATA_W` = 64, `WB_SEL_W` = 8.
  - FSM state enum `wbs_state_t` (IDLE, WAIT, RESP, HOLD).
  - The master reuses the width constants.
- Sub-module `wb_regfile`: `NUM_REGS` x 64 storage with byte-enable write port, one combinational read port, and async active-low clear. Register 0 is hardwired to `ID_VALUE`.
- The top module holds the FSM, address decode, wait counter, and output registers.

## Test plan
- Reset then read: deassert `rst_i`; read `ADDR_BASE` with `WAIT_STATES` = 0 → `ack_o` one cycle after the request; `dat_o` = 64'h5742_534C_0000_0001.
- Byte-lane write/readback: write `ADDR_BASE+8`, `dat_i` = 64'h1122_3344_5566_7788, `sel_i` = 8'hFF; then write 64'hAAAA_AAAA_AAAA_AAAA with `sel_i` = 8'h0F; read back → `dat_o` = 64'h1122_3344_AAAA_AAAA.
- Held strobe: keep `cyc_i`/`stb_i` high 5 cycles after `ack_o` → no second ack; `dat_o` stable; a new request after `stb_i` low is acked normally.
- Out of window: `NUM_REGS` = 16, read `ADDR_BASE+8*16` → `err_o` pulse, `ack_o` = 0, `dat_o` unchanged; write there → err and no register changed.
- Wait states and abort: `WAIT_STATES` = 3, write reg 2 → ack in cycle k+4. Repeat with `stb_i` dropped in cycle k+2 → no ack, reg 2 unchanged.
- Async reset mid-write: assert `rst_i` low during WAIT → `ack_o` = 0 immediately; reg 2 reads 0 after release.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone definitions for the debug-path master and the register-file
// responder: bus widths and the responder FSM state encoding.
package wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 64;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;

  // Responder handshake states.
  //   WBS_IDLE : waiting for cyc & stb, request fields captured here only
  //   WBS_WAIT : optional wait states before the response
  //   WBS_RESP : single-cycle ack/err
  //   WBS_HOLD : absorb a still-asserted strobe so it is answered once
  typedef enum logic [1:0] {
    WBS_IDLE = 2'd0,
    WBS_WAIT = 2'd1,
    WBS_RESP = 2'd2,
    WBS_HOLD = 2'd3
  } wbs_state_t;

endpackage

// File: rtl/wb_regfile.sv
// NUM_REGS x 64-bit register file with a byte-enable write port and one
// combinational read port. Register 0 has no storage and always reads as
// ID_VALUE; registers 1..NUM_REGS-1 clear on the asynchronous reset.
//
// Ports:
//   clk_i    in  1          clock, rising edge
//   rst_i    in  1          asynchronous active-low clear
//   wr_en    in  1          write strobe (ignored for index 0)
//   wr_idx   in  IDX_W      write register index
//   wr_data  in  64         write data
//   wr_sel   in  8          byte-lane enables for the write
//   rd_idx   in  IDX_W      read register index
//   rd_data  out 64         read data (combinational)
module wb_regfile
  import wb_pkg::*;
#(
  parameter int unsigned            NUM_REGS = 16,
  parameter logic [WB_DATA_W-1:0]   ID_VALUE = 64'h5742_534C_0000_0001
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  logic [WB_DATA_W-1:0]        wr_data,
  input  logic [WB_SEL_W-1:0]         wr_sel,
  input  logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic [WB_DATA_W-1:0]        rd_data
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  // Index 0 is the read-only ID word, so storage starts at 1.
  logic [WB_DATA_W-1:0] regs [1:NUM_REGS-1];

  // NOTE: this storage is flop-based and small, so it is cleared by the async
  // reset; a RAM macro could not be, and would need an explicit init sequence.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 1; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (wr_idx == IDX_W'(i)) begin
          for (int b = 0; b < int'(WB_SEL_W); b++) begin
            if (wr_sel[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rd_data = ID_VALUE;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      if (rd_idx == IDX_W'(i)) rd_data = regs[i];
    end
  end

endmodule

// File: rtl/wishbone_slave_regfile.sv
// Wishbone classic-cycle responder in front of a 64-bit register file.
// Decodes a base-relative window, inserts WAIT_STATES cycles, then answers
// every strobe exactly once with ack_o (in window) or err_o (out of window).
// A strobe held after the response is parked in HOLD until it drops.
//
// Ports:
//   clk_i  in  1   clock, rising edge
//   rst_i  in  1   asynchronous active-low reset
//   cyc_i  in  1   bus cycle valid
//   stb_i  in  1   strobe; request = cyc_i & stb_i
//   we_i   in  1   1 = write, 0 = read
//   adr_i  in  32  byte address, bits [2:0] ignored
//   dat_i  in  64  write data
//   sel_i  in  8   byte-lane enables
//   dat_o  out 64  registered read data, held until the next in-window read
//   ack_o  out 1   one-cycle normal termination
//   err_o  out 1   one-cycle error termination
module wishbone_slave_regfile
  import wb_pkg::*;
#(
  parameter logic [WB_ADDR_W-1:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned          NUM_REGS    = 16,
  parameter int unsigned          WAIT_STATES = 0,
  parameter logic [WB_DATA_W-1:0] ID_VALUE    = 64'h5742_534C_0000_0001
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cyc_i,
  input  logic                 stb_i,
  input  logic                 we_i,
  input  logic [WB_ADDR_W-1:0] adr_i,
  input  logic [WB_DATA_W-1:0] dat_i,
  input  logic [WB_SEL_W-1:0]  sel_i,
  output logic [WB_DATA_W-1:0] dat_o,
  output logic                 ack_o,
  output logic                 err_o
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned WORD_W = WB_ADDR_W - 3;
  localparam logic [WORD_W-1:0] BASE_WORD = ADDR_BASE[WB_ADDR_W-1:3];

  wbs_state_t state_q, state_d;

  logic                 req;
  logic [3:0]           cnt_q;
  logic                 we_q, in_win_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WB_DATA_W-1:0] dat_q;
  logic [WB_SEL_W-1:0]  sel_q;

  logic [WORD_W-1:0]    word_off;
  logic                 in_win;
  logic                 cur_we, cur_in_win;
  logic [IDX_W-1:0]     cur_idx;
  logic [WB_DATA_W-1:0] cur_dat;
  logic [WB_SEL_W-1:0]  cur_sel;
  logic                 enter_resp;
  logic                 wr_en;
  logic [WB_DATA_W-1:0] rd_data;
  logic                 unused_adr;

  assign req = cyc_i & stb_i;

  // Word-granular decode; the byte offset within a word is don't-care.
  assign word_off   = adr_i[WB_ADDR_W-1:3] - BASE_WORD;
  assign in_win     = (adr_i[WB_ADDR_W-1:3] >= BASE_WORD) &&
                      (word_off < WORD_W'(NUM_REGS));
  assign unused_adr = ^adr_i[2:0];

  // With zero wait states the response is entered straight from IDLE, on the
  // same edge that captures the request, so the live bus fields are used
  // then; otherwise the captured copies are.
  assign cur_we     = (state_q == WBS_IDLE) ? we_i   : we_q;
  assign cur_in_win = (state_q == WBS_IDLE) ? in_win : in_win_q;
  assign cur_idx    = (state_q == WBS_IDLE) ? word_off[IDX_W-1:0] : idx_q;
  assign cur_dat    = (state_q == WBS_IDLE) ? dat_i  : dat_q;
  assign cur_sel    = (state_q == WBS_IDLE) ? sel_i  : sel_q;

  assign enter_resp = (state_d == WBS_RESP) && (state_q != WBS_RESP);
  assign wr_en      = enter_resp && cur_we && cur_in_win && (cur_idx != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= WBS_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WBS_IDLE: if (req) state_d = (WAIT_STATES > 0) ? WBS_WAIT : WBS_RESP;
      WBS_WAIT: begin
        if (!req)             state_d = WBS_IDLE;  // abort: no write, no response
        else if (cnt_q == '0) state_d = WBS_RESP;
      end
      WBS_RESP: state_d = WBS_HOLD;
      WBS_HOLD: if (!req) state_d = WBS_IDLE;
      default:  state_d = WBS_IDLE;
    endcase
  end

  // Request capture and wait counter; inputs are sampled only in IDLE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q    <= '0;
      we_q     <= 1'b0;
      in_win_q <= 1'b0;
      idx_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
    end else if (state_q == WBS_IDLE && req) begin
      cnt_q    <= (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
      we_q     <= we_i;
      in_win_q <= in_win;
      idx_q    <= word_off[IDX_W-1:0];
      dat_q    <= dat_i;
      sel_q    <= sel_i;
    end else if (state_q == WBS_WAIT && cnt_q != '0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  // Responses are registered so ack_o/err_o rise exactly with the RESP state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= enter_resp &&  cur_in_win;
      err_o <= enter_resp && !cur_in_win;
      if (enter_resp && cur_in_win && !cur_we) dat_o <= rd_data;
    end
  end

  wb_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en   (wr_en),
    .wr_idx  (cur_idx),
    .wr_data (cur_dat),
    .wr_sel  (cur_sel),
    .rd_idx  (cur_idx),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_wishbone_slave_regfile.sv
// Directed bench for wishbone_slave_regfile: one instance with no wait states
// and one with three, sharing clock, reset and address/data/we/sel.
module tb_wishbone_slave_regfile;
  import wb_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [63:0] ID   = 64'h5742_534C_0000_0001;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cyc0, stb0, cyc3, stb3;
  logic        we_i;
  logic [31:0] adr_i;
  logic [63:0] dat_i;
  logic [7:0]  sel_i;
  logic [63:0] dat0, dat3;
  logic        ack0, err0, ack3, err3;

  int   total = 0;
  int   fails = 0;
  int   lat;
  logic a, e;

  always #5 clk_i = ~clk_i;

  wishbone_slave_regfile #(
    .ADDR_BASE (BASE), .NUM_REGS (16), .WAIT_STATES (0), .ID_VALUE (ID)
  ) u_dut0 (
    .clk_i (clk_i), .rst_i (rst_i), .cyc_i (cyc0), .stb_i (stb0),
    .we_i (we_i), .adr_i (adr_i), .dat_i (dat_i), .sel_i (sel_i),
    .dat_o (dat0), .ack_o (ack0), .err_o (err0)
  );

  wishbone_slave_regfile #(
    .ADDR_BASE (BASE), .NUM_REGS (16), .WAIT_STATES (3), .ID_VALUE (ID)
  ) u_dut3 (
    .clk_i (clk_i), .rst_i (rst_i), .cyc_i (cyc3), .stb_i (stb3),
    .we_i (we_i), .adr_i (adr_i), .dat_i (dat_i), .sel_i (sel_i),
    .dat_o (dat3), .ack_o (ack3), .err_o (err3)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single transfer on one instance: raise the request, wait (bounded) for
  // ack/err, then drop the strobe for two cycles so the next request lands
  // in IDLE. lat = edges from request to response, 0 on timeout.
  task automatic bus(input bit on3, input logic we, input logic [31:0] adr,
                     input logic [63:0] dat, input logic [7:0] sel,
                     output int l, output logic ak, output logic er);
    we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    if (on3) begin cyc3 = 1'b1; stb3 = 1'b1; end
    else     begin cyc0 = 1'b1; stb0 = 1'b1; end
    l = 0; ak = 1'b0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (on3 ? (ack3 | err3) : (ack0 | err0)) begin
        l  = n;
        ak = on3 ? ack3 : ack0;
        er = on3 ? err3 : err0;
        break;
      end
    end
    cyc0 = 1'b0; stb0 = 1'b0; cyc3 = 1'b0; stb3 = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc0 = 0; stb0 = 0; cyc3 = 0; stb3 = 0;
    we_i = 0; adr_i = '0; dat_i = '0; sel_i = '0;
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    #2;
    check("reset dat0", dat0, 64'h0);
    check("reset ack0/err0", {ack0, err0}, 2'b00);
    check("reset dat3", dat3, 64'h0);
    tick(); tick();
    rst_i = 1'b1;
    tick();

    // Read of register 0: ack on the edge after the request is sampled.
    adr_i = BASE; we_i = 0; cyc0 = 1; stb0 = 1;
    check("ack before edge", ack0, 1'b0);
    tick();
    check("id read ack", ack0, 1'b1);
    check("id read err", err0, 1'b0);
    check("id read data", dat0, ID);
    cyc0 = 0; stb0 = 0;
    tick();
    check("ack one cycle", ack0, 1'b0);
    tick();

    // Byte-lane write and readback (low address bits ignored on the read).
    bus(0, 1, BASE + 8, 64'h1122_3344_5566_7788, 8'hFF, lat, a, e);
    check("wr full ack", a, 1'b1);
    check("wr full lat", lat, 1);
    bus(0, 1, BASE + 8, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, lat, a, e);
    check("wr lanes ack", a, 1'b1);
    bus(0, 0, BASE + 13, 64'h0, 8'h00, lat, a, e);
    check("lane readback", dat0, 64'h1122_3344_AAAA_AAAA);

    // Held strobe: one response only; bus changes during HOLD are ignored.
    adr_i = BASE + 8; we_i = 0; cyc0 = 1; stb0 = 1;
    tick();
    check("hold first ack", ack0, 1'b1);
    we_i = 1; dat_i = 64'hFFFF_FFFF_FFFF_FFFF; sel_i = 8'hFF;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("hold no resp", {ack0, err0}, 2'b00);
      check("hold dat stable", dat0, 64'h1122_3344_AAAA_AAAA);
    end
    cyc0 = 0; stb0 = 0;
    tick(); tick();
    bus(0, 0, BASE + 8, 64'h0, 8'h00, lat, a, e);
    check("after hold ack", a, 1'b1);
    check("after hold data", dat0, 64'h1122_3344_AAAA_AAAA);

    // Window boundaries and read-only register 0.
    bus(0, 0, BASE + 8*16, 64'h0, 8'h00, lat, a, e);
    check("oob read err/ack", {e, a}, 2'b10);
    check("oob read dat kept", dat0, 64'h1122_3344_AAAA_AAAA);
    bus(0, 0, BASE - 8, 64'h0, 8'h00, lat, a, e);
    check("below base err/ack", {e, a}, 2'b10);
    bus(0, 1, BASE + 8*16, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, a, e);
    check("oob write err/ack", {e, a}, 2'b10);
    bus(0, 1, BASE, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, lat, a, e);
    check("id write ack", {e, a}, 2'b01);
    bus(0, 0, BASE, 64'h0, 8'h00, lat, a, e);
    check("id unchanged", dat0, ID);
    bus(0, 0, BASE + 8*15, 64'h0, 8'h00, lat, a, e);
    check("last reg ack", {e, a}, 2'b01);
    check("last reg data", dat0, 64'h0);
    bus(0, 0, BASE + 8, 64'h0, 8'h00, lat, a, e);
    check("reg1 after oob", dat0, 64'h1122_3344_AAAA_AAAA);

    // Three wait states: ack on the fourth edge; bus changes in WAIT ignored.
    adr_i = BASE + 16; we_i = 1; dat_i = 64'h0123_4567_89AB_CDEF; sel_i = 8'hFF;
    cyc3 = 1; stb3 = 1;
    tick();
    dat_i = 64'h5A5A_5A5A_5A5A_5A5A; adr_i = BASE + 24; we_i = 0;
    check("ws edge k", ack3, 1'b0);
    tick();
    check("ws edge k+1", ack3, 1'b0);
    tick();
    check("ws edge k+2", ack3, 1'b0);
    tick();
    check("ws edge k+3 ack", {ack3, err3}, 2'b10);
    cyc3 = 0; stb3 = 0;
    tick(); tick();
    bus(1, 0, BASE + 16, 64'h0, 8'h00, lat, a, e);
    check("ws read lat", lat, 4);
    check("ws read data", dat3, 64'h0123_4567_89AB_CDEF);

    // Abort during WAIT: no response, no write.
    adr_i = BASE + 16; we_i = 1; dat_i = 64'hFFFF_FFFF_FFFF_FFFF; sel_i = 8'hFF;
    cyc3 = 1; stb3 = 1;
    tick();
    tick();
    stb3 = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("abort no resp", {ack3, err3}, 2'b00);
    end
    cyc3 = 0;
    bus(1, 0, BASE + 16, 64'h0, 8'h00, lat, a, e);
    check("abort reg2 kept", dat3, 64'h0123_4567_89AB_CDEF);

    // Asynchronous reset in the middle of a waited write.
    adr_i = BASE + 16; we_i = 1; dat_i = 64'h5555_5555_5555_5555; sel_i = 8'hFF;
    cyc3 = 1; stb3 = 1;
    tick();
    #2 rst_i = 1'b0;
    #1;
    check("async rst ack3", {ack3, err3}, 2'b00);
    check("async rst dat3", dat3, 64'h0);
    check("async rst dat0", dat0, 64'h0);
    cyc3 = 0; stb3 = 0;
    tick();
    rst_i = 1'b1;
    tick();
    bus(1, 0, BASE + 16, 64'h0, 8'h00, lat, a, e);
    check("post rst reg2 ack", a, 1'b1);
    check("post rst reg2", dat3, 64'h0);
    bus(0, 0, BASE + 8, 64'h0, 8'h00, lat, a, e);
    check("post rst reg1", dat0, 64'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
